// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU op dispatcher: state encoding, counter width
// and default multi-cycle configuration.
package alu_dispatch_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MULTI = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_MULTI = MULTI,
    ST_HOLD  = HOLD
  } state_t;

  localparam int CNT_W = 8;

  localparam logic [3:0] DEF_MC_MASK   = 4'b0100;
  localparam int         DEF_MC_CYCLES = 4;

  // Counter preload for a multi-cycle op; the op completes when it reaches 1.
  function automatic logic [CNT_W-1:0] mc_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/alu_onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder; generalises the old 2-to-4
// ALU enable decoder.
module alu_onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] onehot
);

  for (genvar gi = 0; gi < (1 << SEL_W); gi++) begin : g_dec
    assign onehot[gi] = (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/alu_op_dispatch.sv
// Registered ALU op dispatcher: one-hot unit enables, multi-cycle hold and a
// writeback handshake. Optional illegal-op trapping under ALU_DISPATCH_ILLEGAL_EN.
module alu_op_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int                    SEL_W     = 2,
  parameter logic [(1<<SEL_W)-1:0] MC_MASK   = DEF_MC_MASK,
  parameter int                    MC_CYCLES = DEF_MC_CYCLES
`ifdef ALU_DISPATCH_ILLEGAL_EN
  ,
  parameter logic [(1<<SEL_W)-1:0] LEGAL_MASK = '1
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        op_sel,
  output logic [(1<<SEL_W)-1:0]   out_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
`ifdef ALU_DISPATCH_ILLEGAL_EN
  ,
  output logic                    illegal
`endif
);

  localparam int               N_OPS   = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_LD  = mc_load(MC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_reg;
  logic [N_OPS-1:0]   out_en_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N_OPS-1:0]   dec_onehot;
  logic               accept;
  logic               op_legal;
  logic               op_is_mc;
`ifdef ALU_DISPATCH_ILLEGAL_EN
  logic               illegal_reg;
`endif

  alu_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (op_sel),
    .onehot (dec_onehot)
  );

  // A stalled HOLD can still take a new op when the current one drains this cycle.
  assign in_ready = !flush && ((state_reg == ST_IDLE) ||
                               ((state_reg == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef ALU_DISPATCH_ILLEGAL_EN
  assign op_legal = LEGAL_MASK[op_sel];
`else
  assign op_legal = 1'b1;
`endif
  // Illegal ops never occupy a unit, so they skip the multi-cycle path.
  assign op_is_mc = MC_MASK[op_sel] && op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_en_reg    <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      cnt_reg       <= '0;
`ifdef ALU_DISPATCH_ILLEGAL_EN
      illegal_reg   <= 1'b0;
`endif
    end else if (flush) begin
      state_reg     <= ST_IDLE;
      out_en_reg    <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      cnt_reg       <= '0;
`ifdef ALU_DISPATCH_ILLEGAL_EN
      illegal_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            out_en_reg <= op_legal ? dec_onehot : '0;
`ifdef ALU_DISPATCH_ILLEGAL_EN
            illegal_reg <= !op_legal;
`endif
            if (op_is_mc) begin
              state_reg     <= ST_MULTI;
              cnt_reg       <= CNT_LD;
              busy_reg      <= 1'b1;
              out_valid_reg <= 1'b0;
            end else begin
              state_reg     <= ST_HOLD;
              cnt_reg       <= '0;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end else if ((state_reg == ST_HOLD) && out_ready) begin
            state_reg     <= ST_IDLE;
            out_en_reg    <= '0;
            out_valid_reg <= 1'b0;
`ifdef ALU_DISPATCH_ILLEGAL_EN
            illegal_reg   <= 1'b0;
`endif
          end
        end
        ST_MULTI: begin
          if (cnt_reg == CNT_ONE) begin
            state_reg     <= ST_HOLD;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_en_reg    <= '0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          cnt_reg       <= '0;
        end
      endcase
    end
  end

  assign out_en    = out_en_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
`ifdef ALU_DISPATCH_ILLEGAL_EN
  assign illegal   = illegal_reg;
`endif

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Randomised self-checking bench for alu_op_dispatch against a timestamp-based
// transaction model; honours ALU_DISPATCH_ILLEGAL_EN when defined.
module tb_alu_op_dispatch;

  localparam int         MCC     = 4;
  localparam logic [3:0] MC_CFG  = 4'b0100;
`ifdef ALU_DISPATCH_ILLEGAL_EN
  localparam logic [3:0] LEGAL_CFG = 4'b0111;
`else
  localparam logic [3:0] LEGAL_CFG = 4'b1111;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op_sel;
  logic [3:0] out_en;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef ALU_DISPATCH_ILLEGAL_EN
  logic       illegal;
`endif

  always #5 clk = ~clk;

  alu_op_dispatch #(
    .SEL_W     (2),
    .MC_MASK   (MC_CFG),
    .MC_CYCLES (MCC)
`ifdef ALU_DISPATCH_ILLEGAL_EN
    ,
    .LEGAL_MASK(LEGAL_CFG)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .out_en    (out_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef ALU_DISPATCH_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: at most one op outstanding, valid from a given cycle number onward.
  int         cyc = 0;
  bit         m_have = 1'b0;
  int         m_op = 0;
  int         m_done = 0;
  bit         m_ill = 1'b0;
  logic [3:0] mc_v = MC_CFG;
  logic [3:0] legal_v = LEGAL_CFG;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_valid();
    return m_have && (cyc >= m_done);
  endfunction

  function automatic logic [3:0] m_en();
    return (m_have && !m_ill) ? 4'(1 << m_op) : 4'b0000;
  endfunction

  task automatic check_outputs();
    check_val("out_en", 32'(out_en), 32'(m_en()));
    check_val("out_valid", 32'(out_valid), 32'(m_valid()));
    check_val("busy", 32'(busy), 32'(m_have && !m_valid()));
`ifdef ALU_DISPATCH_ILLEGAL_EN
    check_val("illegal", 32'(illegal), 32'(m_have && m_ill));
`endif
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and registered outputs after.
  task automatic step(input bit f, input bit iv, input int sel, input bit ordy);
    bit exp_rdy;
    bit acc;
    flush     = f;
    in_valid  = iv;
    op_sel    = 2'(sel);
    out_ready = ordy;
    #1;
    exp_rdy = !f && (!m_have || (m_valid() && ordy));
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    @(posedge clk);
    if (f) begin
      if (m_have) $display("txn flush op=%0d cycle %0d", m_op, cyc);
      m_have = 1'b0;
    end else if (acc) begin
      if (m_valid()) $display("txn complete op=%0d cycle %0d", m_op, cyc);
      m_have = 1'b1;
      m_op   = sel;
      m_ill  = !legal_v[sel];
      m_done = cyc + 1 + ((mc_v[sel] && !m_ill) ? MCC - 1 : 0);
      $display("txn accept op=%0d cycle %0d", sel, cyc);
    end else if (m_valid() && ordy) begin
      $display("txn complete op=%0d cycle %0d", m_op, cyc);
      m_have = 1'b0;
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op_sel = 2'd0; out_ready = 1'b0;
    #2;
    check_val("reset_out_en", 32'(out_en), 32'd0);
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single op then drain to idle.
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    // Multi-cycle op with in_valid held high while busy.
    step(0, 1, 2, 1);
    for (int i = 0; i < MCC; i++) step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    // Back-to-back stream.
    step(0, 1, 3, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    // Stall in HOLD, then release.
    step(0, 1, 3, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    // Flush on the second MULTI cycle.
    step(0, 1, 2, 1);
    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);
    // Asynchronous reset mid-MULTI.
    step(0, 1, 2, 1);
    step(0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    m_have = 1'b0;
    check_val("async_rst_out_en", 32'(out_en), 32'd0);
    check_val("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    check_val("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    step(0, 1, 1, 1);
    // Op 3 (illegal when the feature is built in) then handshake.
    step(0, 1, 3, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
           int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_dispatch.md
Name: alu_op_dispatch

Overview:
- Parametrised, registered successor to the 2-to-4 ALU-enable decoder in the execute stage.
- Accepts an encoded ALU op select over a valid/ready handshake and drives a registered one-hot enable vector to the ALU sub-units.
- Holds the enables for multi-cycle ops (e.g. iterative shifter) with an internal down-counter.
- Presents the result-valid handshake to the writeback side, with stall and flush support.

Parameters:
- SEL_W, 2, width of op select; N_OPS = 2**SEL_W (derived localparam, one enable per op).
- MC_MASK, 4'b0100, bit i=1 marks op i as multi-cycle (default: SRAI); width N_OPS.
- MC_CYCLES, 4, cycles a multi-cycle op holds its enable before completing; legal range 2..255.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous pipeline flush, highest priority.
- IN_VALID  in  1  op select valid.
- IN_READY  out  1  block can accept an op this cycle.
- OP_SEL  in  SEL_W  encoded op index.
- OUT_EN  out  N_OPS  registered one-hot unit enables.
- OUT_VALID  out  1  op complete, enables stable for writeback.
- OUT_READY  in  1  downstream accepts the completed op.
- BUSY  out  1  multi-cycle op in progress.

Behaviour:
- States: IDLE, MULTI, HOLD. Encoding is in the shared package.
- Reset (async, RST_N=0): state=IDLE, OUT_EN=0, OUT_VALID=0, BUSY=0, counter=0. Applies immediately, including mid-MULTI. First accept is possible on the first edge after release.
- IN_READY is combinational: (state==IDLE) | (state==HOLD & OUT_READY). It is forced to 0 while FLUSH=1.
- Accept is IN_VALID & IN_READY. On accept, OUT_EN <= one-hot(OP_SEL), then:
  - If MC_MASK[OP_SEL]=1: state <= MULTI, counter <= MC_CYCLES-1.
  - Otherwise: state <= HOLD.
- MULTI:
  - OUT_EN held, OUT_VALID=0, BUSY=1.
  - Counter decrements each cycle. When counter==1, state <= HOLD next edge.
  - IN_VALID is ignored.
- HOLD:
  - OUT_VALID=1, OUT_EN held.
  - If OUT_READY=0 (stall): everything holds indefinitely.
  - If OUT_READY=1 and accept: back-to-back reload per accept rules, with no bubble.
  - If OUT_READY=1 and no accept: state <= IDLE, OUT_EN <= 0.
- Latency from accept edge to OUT_VALID=1:
  - Single-cycle op: 1 cycle.
  - Multi-cycle op: MC_CYCLES cycles.
- Throughput: single-cycle ops sustain 1 op/cycle when OUT_READY=1. A multi-cycle op blocks new accepts for MC_CYCLES cycles.
- FLUSH=1 at an edge: state <= IDLE, OUT_EN <= 0, counter <= 0, regardless of state or simultaneous accept or OUT_READY. The op in flight is discarded.
- OUT_EN is all-zero in IDLE and has exactly one bit set in MULTI and HOLD.
- All outputs except IN_READY are registered.
- Counter width is 8 bits.

Optional Feature:
- Macro: ALU_DISPATCH_ILLEGAL_EN.
- With the macro:
  - Parameter LEGAL_MASK (default all ones, width N_OPS) and output port ILLEGAL (1 bit, reset 0) are added.
  - An accepted op with LEGAL_MASK[OP_SEL]=0 goes directly to HOLD with OUT_EN=0, ILLEGAL=1, OUT_VALID=1. It completes through the normal handshake; MC_MASK is ignored for it.
  - ILLEGAL clears when the op leaves HOLD, and on FLUSH or reset.
- Without the macro: no LEGAL_MASK parameter and no ILLEGAL port; every OP_SEL value is decoded.

Decomposition:
- Shared package alu_dispatch_pkg holds:
  - State encoding localparams: IDLE=2'd0, MULTI=2'd1, HOLD=2'd2.
  - Counter width constant CNT_W=8.
  - Default MC_MASK value.
- One natural sub-module: alu_onehot_dec, a combinational SEL_W-to-2**SEL_W one-hot decoder (the generalised enable decoder). It is instantiated once; its output feeds the OUT_EN register.

Test Plan:
- Reset then OP_SEL=0 with IN_VALID=1 and OUT_READY=1 → 1 cycle later OUT_EN=4'b0001, OUT_VALID=1; next cycle, with no new op, OUT_EN=0 and state IDLE.
- OP_SEL=2 (multi-cycle, MC_CYCLES=4) → OUT_EN=4'b0100 and BUSY=1 for 3 cycles, OUT_VALID=1 on cycle 4, IN_READY=0 throughout MULTI.
- Stream OP_SEL=3,1,0 on consecutive cycles with OUT_READY=1 → OUT_EN=1000,0010,0001 on consecutive cycles, no bubbles.
- In HOLD with OP_SEL=3 and OUT_READY=0 for 5 cycles → OUT_EN=4'b1000 and OUT_VALID stable, IN_READY=0; release OUT_READY → IDLE next cycle.
- FLUSH asserted on cycle 2 of MULTI (OP_SEL=2) → next edge OUT_EN=0, BUSY=0, OUT_VALID=0. Separately, RST_N low mid-MULTI → outputs zero immediately, without waiting for a clock edge.
- With ALU_DISPATCH_ILLEGAL_EN and LEGAL_MASK=4'b0111, OP_SEL=3 → OUT_EN=0, ILLEGAL=1, OUT_VALID=1 after 1 cycle; ILLEGAL clears after the OUT_READY handshake.
